systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 4: array dimension and number of lanes.
REQ-002 Parameter DW, default 4: data and weight element width.
REQ-003 Parameter KW, default 4: width of the vector-count field.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin a tile.
REQ-007 k_len  input  KW  number of vectors in the tile; sampled when start is accepted.
REQ-008 s_valid  input  1  upstream vector valid.
REQ-009 s_ready  output  1  feeder accepts a vector this cycle.
REQ-010 s_data  input  N*DW  column data vector; lane i occupies bits [i*DW +: DW].
REQ-011 s_weight  input  N*DW  row weight vector; same lane packing as s_data.
REQ-012 res_ack  input  1  consumer has captured the array results.
REQ-013 arr_data  output  N*DW  skewed data to the array top edge, lane j feeding column j.
REQ-014 arr_weight  output  N*DW  skewed weights to the array left edge, lane i feeding row i.
REQ-015 compute_en  output  1  array MAC enable; low clears all PE accumulators.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 results_valid  output  1  all PE accumulators hold final tile results.

Function
REQ-018 The FSM SHALL have states IDLE, STREAM, FLUSH and DONE; the encoding is an enum in the shared package.
REQ-019 IDLE->STREAM SHALL occur on start=1 with k_len!=0; start with k_len=0, or start in any state other than IDLE, SHALL be ignored.
REQ-020 s_ready SHALL equal (state==STREAM); a vector is accepted when s_valid && s_ready.
REQ-021 In STREAM, a cycle with s_valid=0 SHALL inject an all-zero vector into the skew lines (bubble) without counting it as a vector.
REQ-022 STREAM->FLUSH SHALL occur on the edge that accepts vector number k_len; in FLUSH, zero vectors SHALL be injected.
REQ-023 FLUSH SHALL last exactly 2N-1 cycles; DONE SHALL be entered on the (2N-1)th edge after the last acceptance edge.
REQ-024 DONE->IDLE SHALL occur on res_ack=1; res_ack outside DONE SHALL be ignored.
REQ-025 Lane i of arr_data and arr_weight SHALL present the injected vector element i after exactly i+1 clock edges; outputs SHALL be registered.
REQ-026 compute_en SHALL be 1 in STREAM, FLUSH and DONE, and 0 in IDLE.
REQ-027 results_valid SHALL be 1 only in DONE; arr_data and arr_weight SHALL be all-zero throughout DONE.
REQ-028 The accepted-vector counter SHALL be KW bits wide and SHALL compare against the k_len value latched at start.
REQ-029 Array results are 2*DW bits wide and wrap modulo 2^(2*DW); the feeder SHALL NOT detect or flag overflow.

Reset
REQ-030 While reset_n=0, the FSM SHALL be in IDLE, all skew registers and counters SHALL be 0, and arr_data, arr_weight, compute_en, busy, results_valid and s_ready SHALL all be 0.
REQ-031 Reset asserted in any state, including mid-STREAM or mid-FLUSH, SHALL abort the tile with no partial results_valid pulse.

Structure
REQ-032 Package systolic_pkg SHALL hold N, DW, the result width 2*DW, FLUSH_CYC=2N-1, and the FSM state enum.
REQ-033 Sub-module skew_line (parameters DW and DEPTH, plus clk and reset_n) SHALL implement one lane delay chain and SHALL be instantiated 2N times.

Verification
REQ-034 K=2, all data lanes 3, all weights 2, s_valid continuously 1 -> every PE result is 12; results_valid rises 7 edges after the second acceptance.
REQ-035 K=1, data lane j = j+1, weights lane i = 1 -> arr_data lane j is nonzero only in the cycle after edge j+1 following acceptance; arr_weight shows the same pattern.
REQ-036 K=3 with s_valid low for 3 cycles after the first vector -> results identical to the same tile without the gap; results_valid is delayed by exactly 3 cycles.
REQ-037 K=2, all values 15 -> every PE result is 194 (450 mod 256).
REQ-038 reset_n pulsed low in FLUSH cycle 3 -> all outputs are 0 immediately, the FSM is in IDLE, no results_valid occurs, and the next start runs a clean tile.
REQ-039 start with k_len=0, and start during STREAM -> both are ignored; busy and the state are unchanged.

Source files
------------

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic-array feeder:
//   N, DW      default array dimension and element width
//   RW         width of one PE accumulator (products wrap modulo 2^RW)
//   FLUSH_CYC  drain cycles after the last vector (2N-1)
//   state_t    feeder FSM encoding
//   ctrl_t     registered control outputs decoded per state
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int RW = 2 * DW;

  // The last element injected into lane N-1 still has to ripple across
  // N-1 PEs in each direction, hence 2N-1 drain cycles.
  function automatic int flush_len(input int n);
    return 2 * n - 1;
  endfunction

  localparam int FLUSH_CYC = flush_len(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic s_ready;
    logic busy;
    logic compute_en;
    logic results_valid;
  } ctrl_t;

  // Control outputs are loaded together with the state they belong to,
  // so every output is a flop rather than a decode of the state register.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    // NOTE: give every field a default before the case so no path leaves a
    // bit unassigned; the same habit is what keeps always_comb latch-free.
    c = '0;
    case (s)
      STREAM: begin
        c.s_ready    = 1'b1;
        c.busy       = 1'b1;
        c.compute_en = 1'b1;
      end
      FLUSH: begin
        c.busy       = 1'b1;
        c.compute_en = 1'b1;
      end
      DONE: begin
        c.busy          = 1'b1;
        c.compute_en    = 1'b1;
        c.results_valid = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// One lane of the input skew: a DEPTH-stage register chain, so the value on
// d appears on q after exactly DEPTH rising edges. q is a flop output.
//   clk      clock
//   reset_n  asynchronous active-low reset, clears every stage
//   d        element injected this cycle
//   q        element injected DEPTH edges ago
// -----------------------------------------------------------------------------
module skew_line #(
  parameter int DW    = 4,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DEPTH-1:0][DW-1:0] pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these stages are plain flops, not a RAM, so they are reset;
      // an aborted tile must not leave stale elements in flight.
      pipe <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the old value
      // of its predecessor, which is what turns this into a shift chain.
      pipe[0] <= d;
      for (int k = 1; k < DEPTH; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Streams k_len data/weight vectors into an N x N output-stationary systolic
// array, skewing lane i by i+1 cycles, then drains the array with zeros and
// holds results_valid until the consumer acknowledges.
//   clk, reset_n        clock, asynchronous active-low reset
//   start, k_len        begin a tile of k_len vectors (ignored unless IDLE)
//   s_valid, s_ready    upstream vector handshake
//   s_data, s_weight    lane i in bits [i*DW +: DW]
//   res_ack             consumer captured the results (only seen in DONE)
//   arr_data            skewed column inputs, lane j -> column j
//   arr_weight          skewed row inputs, lane i -> row i
//   compute_en          PE MAC enable; low clears the accumulators
//   busy                any state other than IDLE
//   results_valid       accumulators hold the final tile results
// -----------------------------------------------------------------------------
module systolic_feeder #(
  parameter int N  = systolic_pkg::N,
  parameter int DW = systolic_pkg::DW,
  parameter int KW = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N*DW-1:0] s_data,
  input  logic [N*DW-1:0] s_weight,
  input  logic            res_ack,
  output logic [N*DW-1:0] arr_data,
  output logic [N*DW-1:0] arr_weight,
  output logic            compute_en,
  output logic            busy,
  output logic            results_valid
);

  import systolic_pkg::*;

  localparam int              FLUSH_LEN = flush_len(N);
  localparam int              FCW       = $clog2(FLUSH_LEN + 1);
  localparam logic [KW-1:0]   K_ONE     = KW'(1);
  localparam logic [FCW-1:0]  F_ONE     = FCW'(1);
  localparam logic [FCW-1:0]  F_LAST    = FCW'(FLUSH_LEN - 1);

  state_t          state;
  ctrl_t           ctrl;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   acc_cnt;
  logic [FCW-1:0]  flush_cnt;

  logic            accept;
  logic [N*DW-1:0] inj_data;
  logic [N*DW-1:0] inj_weight;

  assign accept = s_valid && ctrl.s_ready;

  // Bubbles in STREAM and every cycle outside STREAM inject zeros, so the
  // skew lines drain cleanly and the array sees nothing in DONE.
  assign inj_data   = accept ? s_data   : '0;
  assign inj_weight = accept ? s_weight : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ctrl      <= '0;
      k_q       <= '0;
      acc_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (k_len != '0)) begin
            state   <= STREAM;
            ctrl    <= ctrl_of(STREAM);
            k_q     <= k_len;
            acc_cnt <= '0;
          end
        end
        STREAM: begin
          if (s_valid) begin
            // acc_cnt counts vectors already accepted, so this edge takes
            // vector number acc_cnt+1.
            if (acc_cnt == k_q - K_ONE) begin
              state     <= FLUSH;
              ctrl      <= ctrl_of(FLUSH);
              acc_cnt   <= '0;
              flush_cnt <= '0;
            end else begin
              acc_cnt <= acc_cnt + K_ONE;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == F_LAST) begin
            state     <= DONE;
            ctrl      <= ctrl_of(DONE);
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + F_ONE;
          end
        end
        DONE: begin
          if (res_ack) begin
            state <= IDLE;
            ctrl  <= ctrl_of(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          ctrl  <= '0;
        end
      endcase
    end
  end

  assign s_ready       = ctrl.s_ready;
  assign busy          = ctrl.busy;
  assign compute_en    = ctrl.compute_en;
  assign results_valid = ctrl.results_valid;

  // Lane i is delayed i+1 edges so element i of a vector meets its partners
  // on the array diagonal.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(
      .DW    (DW),
      .DEPTH (i + 1)
    ) u_data_skew (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (inj_data[i*DW +: DW]),
      .q       (arr_data[i*DW +: DW])
    );

    skew_line #(
      .DW    (DW),
      .DEPTH (i + 1)
    ) u_weight_skew (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (inj_weight[i*DW +: DW]),
      .q       (arr_weight[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
// Directed bench for systolic_feeder: a table of whole tiles with hand-computed
// PE results and DONE latencies, plus hand-written sequences for the skew
// pattern, ignored requests and an abort by reset in FLUSH. A small
// output-stationary array model consumes arr_data/arr_weight/compute_en.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int KW = 4;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [VW-1:0] s_data = '0;
  logic [VW-1:0] s_weight = '0;
  logic          res_ack = 1'b0;
  logic [VW-1:0] arr_data;
  logic [VW-1:0] arr_weight;
  logic          compute_en;
  logic          busy;
  logic          results_valid;

  systolic_feeder #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .k_len         (k_len),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_weight      (s_weight),
    .res_ack       (res_ack),
    .arr_data      (arr_data),
    .arr_weight    (arr_weight),
    .compute_en    (compute_en),
    .busy          (busy),
    .results_valid (results_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- array model (the consumer of the feeder) ----------------
  logic [7:0]    acc [N][N];
  logic [DW-1:0] a_r [N][N];
  logic [DW-1:0] b_r [N][N];

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    return (j == 0) ? arr_weight[i*DW +: DW] : a_r[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in(input int i, input int j);
    return (i == 0) ? arr_data[j*DW +: DW] : b_r[i-1][j];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || !compute_en) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j] <= '0;
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_r[i][j] <= a_in(i, j);
          b_r[i][j] <= b_in(i, j);
          acc[i][j] <= acc[i][j] + ({4'b0, a_in(i, j)} * {4'b0, b_in(i, j)});
        end
      end
    end
  end

  function automatic logic [127:0] pe_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        f[(i*N + j)*8 +: 8] = acc[i][j];
      end
    end
    return f;
  endfunction

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for results_valid with a bounded budget; returns the edge it saw.
  task automatic wait_done(input string name, output int at_cyc);
    for (int c = 0; c < 40 && !results_valid; c++) step();
    check({name, "_done_seen"}, results_valid, 1'b1);
    at_cyc = cyc;
  endtask

  task automatic ack_tile(input string name);
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    check({name, "_idle_after_ack"}, {busy, results_valid, compute_en, s_ready}, 4'b0000);
  endtask

  // ---------------- tile table ----------------
  typedef struct {
    string              name;
    logic [KW-1:0]      k;
    logic [2:0][VW-1:0] dv;
    logic [2:0][VW-1:0] wv;
    int                 gap;   // bubbles after the first vector
    int                 lat;   // edges from start acceptance to DONE entry
    logic [15:0][7:0]   exp;   // PE (i,j) at index i*N+j
  } tile_t;

  tile_t tbl [6];

  task automatic run_tile(input tile_t r);
    int t0;
    int t1;
    start = 1'b1;
    k_len = r.k;
    step();
    start = 1'b0;
    k_len = '0;
    t0 = cyc;
    check({r.name, "_stream_flags"}, {busy, s_ready, compute_en, results_valid}, 4'b1110);
    for (int v = 0; v < int'(r.k); v++) begin
      s_valid  = 1'b1;
      s_data   = r.dv[v];
      s_weight = r.wv[v];
      step();
      if (v == 0) begin
        // Garbage on the bus during bubbles must not reach the array.
        for (int g = 0; g < r.gap; g++) begin
          s_valid  = 1'b0;
          s_data   = '1;
          s_weight = '1;
          step();
        end
      end
    end
    s_valid  = 1'b0;
    s_data   = '0;
    s_weight = '0;
    wait_done(r.name, t1);
    check({r.name, "_latency"}, 128'(t1 - t0), 128'(r.lat));
    check({r.name, "_pe_results"}, pe_flat(), r.exp);
    check({r.name, "_done_outputs"}, {arr_data, arr_weight, busy, compute_en, s_ready}, {32'h0, 3'b110});
    step();
    check({r.name, "_done_holds"}, results_valid, 1'b1);
    ack_tile(r.name);
  endtask

  // ---------------- stimulus ----------------
  logic [VW-1:0] skew_d [5];
  logic [VW-1:0] skew_w [5];
  int            t_last;
  int            t_done;
  logic          rv_seen;

  initial begin
    tbl[0] = '{"k2_uniform", 4'd2, {16'h0, 16'h3333, 16'h3333}, {16'h0, 16'h2222, 16'h2222},
               0, 9, {16{8'd12}}};
    tbl[1] = '{"k2_wrap", 4'd2, {16'h0, 16'hFFFF, 16'hFFFF}, {16'h0, 16'hFFFF, 16'hFFFF},
               0, 9, {16{8'd194}}};
    tbl[2] = '{"k1_product", 4'd1, {16'h0, 16'h0, 16'h4321}, {16'h0, 16'h0, 16'h4321},
               0, 8, {8'd16, 8'd12, 8'd8, 8'd4,  8'd12, 8'd9, 8'd6, 8'd3,
                      8'd8,  8'd6,  8'd4, 8'd2,  8'd4,  8'd3, 8'd2, 8'd1}};
    tbl[3] = '{"k2_mixed", 4'd2, {16'h0, 16'h3210, 16'h1111}, {16'h0, 16'h2222, 16'h3210},
               0, 9, {8'd9, 8'd7, 8'd5, 8'd3,  8'd8, 8'd6, 8'd4, 8'd2,
                      8'd7, 8'd5, 8'd3, 8'd1,  8'd6, 8'd4, 8'd2, 8'd0}};
    tbl[4] = '{"k3_nogap", 4'd3, {16'h0001, 16'h2222, 16'h1234}, {16'h4444, 16'h0123, 16'h1111},
               0, 10, {8'd1, 8'd2, 8'd3, 8'd8,   8'd3, 8'd4, 8'd5, 8'd10,
                       8'd5, 8'd6, 8'd7, 8'd12,  8'd7, 8'd8, 8'd9, 8'd14}};
    tbl[5] = tbl[4];
    tbl[5].name = "k3_gap3";
    tbl[5].gap  = 3;
    tbl[5].lat  = 13;

    skew_d = '{16'h0001, 16'h0020, 16'h0300, 16'h4000, 16'h0000};
    skew_w = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'h0000};

    // Reset state, including a clock edge with reset held.
    #12;
    check("reset_outputs", {arr_data, arr_weight, compute_en, busy, results_valid, s_ready}, '0);
    step();
    reset_n = 1'b1;
    step();
    check("idle_after_reset", {busy, s_ready, compute_en, results_valid}, 4'b0000);

    // Whole tiles from the table.
    for (int t = 0; t < 6; t++) run_tile(tbl[t]);

    // Skew pattern of a single vector.
    start = 1'b1;
    k_len = 4'd1;
    step();
    start = 1'b0;
    check("skew_pre_accept", {arr_data, arr_weight}, '0);
    s_valid  = 1'b1;
    s_data   = 16'h4321;
    s_weight = 16'h1111;
    step();
    s_valid  = 1'b0;
    s_data   = '0;
    s_weight = '0;
    for (int m = 0; m < 5; m++) begin
      check($sformatf("skew_data_m%0d", m), arr_data, skew_d[m]);
      check($sformatf("skew_weight_m%0d", m), arr_weight, skew_w[m]);
      step();
    end
    wait_done("skew", t_done);
    ack_tile("skew");

    // Ignored requests: start with k_len=0, start and res_ack mid-tile.
    start = 1'b1;
    k_len = 4'd0;
    step();
    start = 1'b0;
    check("k0_start_ignored", {busy, s_ready}, 2'b00);
    start = 1'b1;
    k_len = 4'd2;
    step();
    start    = 1'b0;
    s_valid  = 1'b1;
    s_data   = 16'h3333;
    s_weight = 16'h2222;
    step();
    s_valid = 1'b0;
    start   = 1'b1;
    k_len   = 4'd1;
    step();
    start = 1'b0;
    k_len = '0;
    check("restart_ignored", {busy, s_ready}, 2'b11);
    s_valid = 1'b1;
    step();
    s_valid  = 1'b0;
    s_data   = '0;
    s_weight = '0;
    t_last   = cyc;
    res_ack  = 1'b1;
    step();
    res_ack = 1'b0;
    check("ack_in_flush_ignored", {busy, compute_en, s_ready, results_valid}, 4'b1100);
    wait_done("ignored", t_done);
    check("ignored_latency", 128'(t_done - t_last), 128'd7);
    check("ignored_pe_results", pe_flat(), {16{8'd12}});
    ack_tile("ignored");

    // Abort by reset in the third FLUSH cycle.
    start = 1'b1;
    k_len = 4'd2;
    step();
    start    = 1'b0;
    s_valid  = 1'b1;
    s_data   = 16'h3333;
    s_weight = 16'h2222;
    step();
    step();
    s_valid  = 1'b0;
    s_data   = '0;
    s_weight = '0;
    step();
    step();
    check("abort_in_flush", {busy, compute_en, s_ready}, 3'b110);
    reset_n = 1'b0;
    #1;
    check("abort_outputs_zero", {arr_data, arr_weight, compute_en, busy, results_valid, s_ready}, '0);
    step();
    reset_n = 1'b1;
    rv_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      rv_seen = rv_seen | results_valid | busy;
    end
    check("abort_no_results", rv_seen, 1'b0);
    run_tile(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

endmodule
